accum_feeder: RTL and testbench
===============================

# accum_feeder

Input-side sequencer for the `Accum` datapath. It takes a valid/ready sample stream into a small FIFO and drains it into the accumulator as `Data`/`En` beats. It groups samples into fixed-length frames: one-cycle `Clr` before each frame, one-cycle `FrameDone` when the accumulator output holds the complete frame sum. It sits directly upstream of `Accum` and drives its `Data` and `En` inputs.

## Interface
- `n`, default 6: sample width; must match the downstream `Accum` width.
- `DEPTH`, default 4: FIFO entries; a power of 2, ≥2.
- `FRAME`, default 4: samples per frame; ≥1.
- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `InValid`  in  1  upstream sample valid.
- `InReady`  out  1  FIFO can accept; equals `Level < DEPTH`.
- `InData`  in  n  upstream sample.
- `Data`  out  n  sample to `Accum` (registered).
- `En`  out  1  accumulate strobe to `Accum` (registered).
- `Clr`  out  1  accumulator clear request; high for exactly one cycle per frame.
- `FrameDone`  out  1  one-cycle pulse; the accumulator output equals the frame sum.
- `Level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Push:** occurs on an edge where `InValid && InReady`. When full, a push is refused even if a pop happens in the same cycle.
- **FIFO pointers:** read and write pointers are $clog2(DEPTH)+1 bits and wrap naturally. Full and empty come from pointer compare. Order is strictly FIFO; no sample is dropped or duplicated.
- **State machine:** CLEAR, FEED, LAST, DONE.
  - CLEAR: `Clr`=1. Sample counter := 0. Next state is FEED.
  - FEED: if the FIFO is non-empty on an edge, pop the head into `Data`, set `En`:=1, and increment the counter. If that pop is sample FRAME, go to LAST. If the FIFO is empty, `En`:=0.
  - LAST: the final `En` beat is on the bus; no pop. Next state is DONE.
  - DONE: `FrameDone`=1; no pop. Next state is CLEAR.
- `Clr` and `FrameDone` are decodes of the state register. `En` and `Data` are flops.
- `Data` holds the last popped value while `En`=0; it is not zeroed.
- A push into an empty FIFO and a pop in the same cycle cannot coincide, because the pop sees empty. The sample is popped on the next edge.
- The FIFO keeps accepting samples during LAST, DONE and CLEAR. Samples beyond a frame carry into the next frame.
- **Reset, including mid-frame:**
  - FIFO is flushed and the partial frame is discarded. The counter is cleared and the state becomes CLEAR.
  - `InData` is ignored while `Reset`=1.

## Timing
- **Reset values:**
  - `En`=0, `Data`=0, `Level`=0, `FrameDone`=0, `InReady`=1.
  - State is CLEAR, so `Clr`=1 in the first cycle after `Reset` falls.
- **Latency:** a sample accepted at edge k is popped at edge k+1 if the FIFO was empty and the state is FEED. `Data`/`En` are valid in the cycle after edge k+1, and `Accum` absorbs the sample at edge k+2.
- **Throughput:** one sample per cycle in FEED.
- **Frame overhead:** 3 non-feeding cycles (LAST, DONE, CLEAR) per frame.
- **FrameDone position:** exactly one cycle after the last `En` of the frame, so the `Accum` `Q` output already includes the final sample.
- **Clr position:** `Clr` follows `FrameDone` by one cycle, and the next frame's first `En` follows `Clr` by at least one cycle.
- `Level` updates on the edge of the push or pop. A simultaneous push and pop leaves it unchanged.

## Configuration
- **`ACCUM_FEEDER_PAUSE_EN` defined:**
  - Adds input `Pause` (1 bit).
  - While `Pause`=1 in FEED, there are no pops and `En`:=0. The counter holds and the FIFO still accepts pushes.
  - `Pause` has no effect in LAST, DONE or CLEAR.
- **`ACCUM_FEEDER_PAUSE_EN` undefined:** the port is absent and behaviour is identical to `Pause` tied to 0.

## Test plan
1. **Reset:** `Reset`=1 for 2 cycles with `InValid`=1, `InData`=5 → `Level`=0, `En`=0, `Data`=0, `InReady`=1, nothing accepted; `Clr`=1 for exactly the first cycle after release.
2. **Back-to-back frame:** FRAME=4; push 2, 4, 7, 1 on consecutive cycles → `En` high for 4 consecutive cycles with `Data` 2, 4, 7, 1; `FrameDone` one cycle after the last `En` with `Accum` `Q`=14; `Clr` on the next cycle; `Q`=0 afterwards.
3. **Sparse input:** push one sample every 3 cycles → isolated single-cycle `En` pulses; `FrameDone` only after the 4th pulse; `Data` holds between pulses.
4. **Full FIFO** (macro defined): `Pause`=1, offer 5 samples 1..5 → `Level`=4, `InReady`=0, 5th sample held by the source; release `Pause` → `Data` 1, 2, 3, 4, then 5, in order, with no loss.
5. **Reset mid-frame:** after 2 `En` beats with 2 samples queued, assert `Reset` for 1 cycle → `Level`=0, `En`=0, `Clr` after release; the next frame needs 4 fresh samples before `FrameDone`.
6. **Pointer wrap:** stream 20 samples 0..19 with random `InValid` gaps → output order is exactly 0..19; 5 `FrameDone` pulses; per-frame sums are 6, 22, 38, 54, 70.

Source files
------------

// File: rtl/accum_feeder.sv
// accum_feeder: FIFO-buffered sample sequencer that feeds an accumulator in fixed-length frames.
// Optional `ACCUM_FEEDER_PAUSE_EN adds a Pause input that stalls draining while in FEED.
module accum_feeder #(
   parameter int n     = 6,
   parameter int DEPTH = 4,
   parameter int FRAME = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
`ifdef ACCUM_FEEDER_PAUSE_EN
   input  logic                     Pause,
`endif
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [n-1:0]             InData,
   output logic [n-1:0]             Data,
   output logic                     En,
   output logic                     Clr,
   output logic                     FrameDone,
   output logic [$clog2(DEPTH):0]   Level
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(FRAME + 1);

   typedef enum logic [1:0] {
      S_CLEAR = 2'd0,
      S_FEED  = 2'd1,
      S_LAST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [n-1:0]    data_q, data_d;
   logic            en_q, en_d;
   logic [n-1:0]    mem_q [DEPTH];

   logic            empty_s;
   logic            full_s;
   logic            push_s;
   logic            pop_s;
   logic            pause_s;

`ifdef ACCUM_FEEDER_PAUSE_EN
   assign pause_s = Pause;
`else
   assign pause_s = 1'b0;
`endif

   // FIFO status, handshake and pointer updates
   always_comb begin
      empty_s  = (wr_ptr_q == rd_ptr_q);
      // Same slot index but opposite wrap bit means the FIFO is full
      full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      push_s   = InValid && !full_s;
      pop_s    = (state_q == S_FEED) && !empty_s && !pause_s;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Frame sequencing and the accumulator-side beat
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      en_d    = 1'b0;
      data_d  = data_q;
      case (state_q)
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_FEED;
         end
         S_FEED: begin
            if (pop_s) begin
               en_d   = 1'b1;
               data_d = mem_q[rd_ptr_q[AW-1:0]];
               cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
               if (cnt_q == CW'(FRAME - 1)) begin
                  state_d = S_LAST;
               end else begin
                  state_d = S_FEED;
               end
            end else begin
               en_d    = 1'b0;
               state_d = S_FEED;
            end
         end
         S_LAST: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_CLEAR;
         end
         default: begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   // Control and datapath registers; reset flushes the FIFO and abandons the frame
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= S_CLEAR;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         en_q     <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         data_q   <= data_d;
      end
   end

   // FIFO storage
   always_ff @(posedge Clk) begin
      if (!Reset && push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= InData;
      end
   end

   assign InReady   = !full_s;
   assign Level     = wr_ptr_q - rd_ptr_q;
   assign Data      = data_q;
   assign En        = en_q;
   assign Clr       = (state_q == S_CLEAR);
   assign FrameDone = (state_q == S_DONE);

endmodule

// File: tb/tb_accum_feeder.sv
// Self-checking bench for accum_feeder: cycle-level queue/frame reference model plus an Accum model.
module tb_accum_feeder;
   localparam int N     = 6;
   localparam int DEPTH = 4;
   localparam int FRAME = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
   localparam int VW    = N + LW + 4;

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          InValid = 1'b0;
   logic [N-1:0]  InData = '0;
`ifdef ACCUM_FEEDER_PAUSE_EN
   logic          Pause = 1'b0;
`endif
   logic          InReady, En, Clr, FrameDone;
   logic [N-1:0]  Data;
   logic [LW-1:0] Level;

   accum_feeder #(.n(N), .DEPTH(DEPTH), .FRAME(FRAME)) dut (
      .Clk(Clk),
      .Reset(Reset),
`ifdef ACCUM_FEEDER_PAUSE_EN
      .Pause(Pause),
`endif
      .InValid(InValid),
      .InReady(InReady),
      .InData(InData),
      .Data(Data),
      .En(En),
      .Clr(Clr),
      .FrameDone(FrameDone),
      .Level(Level)
   );

   always #5 Clk = ~Clk;

   // Reference model: queue of accepted samples, samples fed in this frame,
   // and number of non-feeding cycles left after a frame (3=LAST-like,2=done,1=clear)
   int m_q[$];
   int m_fed = 0, m_tail = 1, m_en = 0, m_data = 0, m_run_sum = 0, m_last_sum = 0;
   int acc = 0;
   int en_log[$];
   int sums_obs[$];
   int n_cmp = 0, n_fail = 0;

   function automatic logic [VW-1:0] expv();
      logic [LW-1:0] lv;
      lv = LW'(m_q.size());
      return {m_en[0], N'(m_data), (m_tail == 1), (m_tail == 2), lv, (m_q.size() < DEPTH)};
   endfunction

   function automatic logic [VW-1:0] obsv();
      return {En, Data, Clr, FrameDone, Level, InReady};
   endfunction

   task automatic step(input logic rst, input logic v, input int d, input logic p, output logic accepted);
      int   sz;
      logic pop, push;
      Reset   = rst;
      InValid = v;
      InData  = N'(d);
`ifdef ACCUM_FEEDER_PAUSE_EN
      Pause   = p;
`endif
      if (Clr === 1'b1) acc = 0;
      else if (En === 1'b1) acc += int'(Data);
      @(posedge Clk);
      sz = m_q.size();
      accepted = 1'b0;
      if (rst) begin
         m_q.delete();
         m_fed = 0; m_tail = 1; m_en = 0; m_data = 0; m_run_sum = 0;
      end else begin
         pop  = (m_tail == 0) && (sz > 0) && !p;
         push = v && (sz < DEPTH);
         if (pop) begin
            m_data = m_q.pop_front();
            m_en = 1;
            m_fed++;
            m_run_sum += m_data;
            if (m_fed == FRAME) begin
               m_last_sum = m_run_sum; m_run_sum = 0; m_fed = 0; m_tail = 3;
            end
         end else begin
            m_en = 0;
            if (m_tail > 0) m_tail--;
         end
         if (push) begin
            m_q.push_back(d % (1 << N));
            accepted = 1'b1;
         end
      end
      #1;
      if (En === 1'b1) en_log.push_back(int'(Data));
      if (FrameDone === 1'b1) sums_obs.push_back(acc);
   endtask

   task automatic test_reset();
      logic a;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 5, 1'b0, a);
         n_cmp++;
         if (obsv() !== expv()) begin
            n_fail++; $display("FAIL reset_vec dut=%h model=%h", obsv(), expv());
         end
      end
      n_cmp++;
      if ({Level, En, Data, InReady, Clr} !== {LW'(0), 1'b0, N'(0), 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL reset_vals Level=%0d En=%b Data=%0d InReady=%b Clr=%b", Level, En, Data, InReady, Clr);
      end
      step(1'b0, 1'b0, 0, 1'b0, a);
      n_cmp++;
      if (Clr !== 1'b0) begin
         n_fail++; $display("FAIL reset_clr_once Clr=%b required 0", Clr);
      end
   endtask

   task automatic test_back_to_back();
      logic a;
      int vals[4] = '{2, 4, 7, 1};
      en_log.delete(); sums_obs.delete();
      for (int i = 0; i < 12; i++) begin
         step(1'b0, i < 4, (i < 4) ? vals[i] : 0, 1'b0, a);
         n_cmp++;
         if (obsv() !== expv()) begin
            n_fail++; $display("FAIL b2b_vec cyc=%0d dut=%h model=%h", i, obsv(), expv());
         end
      end
      n_cmp++;
      if (en_log.size() != 4) begin
         n_fail++; $display("FAIL b2b_beats got=%0d required=4", en_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (en_log[i] != vals[i]) begin
               n_fail++; $display("FAIL b2b_data idx=%0d got=%0d required=%0d", i, en_log[i], vals[i]);
            end
         end
      end
      n_cmp++;
      if (sums_obs.size() != 1 || sums_obs[0] != 14) begin
         n_fail++; $display("FAIL b2b_sum pulses=%0d sum=%0d required 1 pulse sum 14", sums_obs.size(), (sums_obs.size() > 0) ? sums_obs[0] : -1);
      end
      n_cmp++;
      if (acc != 0) begin
         n_fail++; $display("FAIL b2b_q_after_clr got=%0d required=0", acc);
      end
   endtask

   task automatic test_sparse();
      logic a;
      int vals[$];
      int sum = 0;
      en_log.delete(); sums_obs.delete();
      for (int i = 0; i < 18; i++) begin
         int d;
         d = $urandom_range(0, (1 << N) - 1);
         if (i % 3 == 0 && i < 12) begin
            vals.push_back(d); sum += d;
         end
         step(1'b0, (i % 3 == 0) && (i < 12), d, 1'b0, a);
         n_cmp++;
         if (obsv() !== expv()) begin
            n_fail++; $display("FAIL sparse_vec cyc=%0d dut=%h model=%h", i, obsv(), expv());
         end
         n_cmp++;
         if (FrameDone === 1'b1 && en_log.size() != 4) begin
            n_fail++; $display("FAIL sparse_early_done beats=%0d required=4", en_log.size());
         end
      end
      n_cmp++;
      if (en_log != vals) begin
         n_fail++; $display("FAIL sparse_data got=%p required=%p", en_log, vals);
      end
      n_cmp++;
      if (sums_obs.size() != 1 || sums_obs[0] != sum) begin
         n_fail++; $display("FAIL sparse_sum got=%p required=%0d", sums_obs, sum);
      end
   endtask

   task automatic test_full();
      logic a;
      logic saw_full = 1'b0;
      int vals[$];
      int idx = 0;
      en_log.delete(); sums_obs.delete();
      for (int i = 0; i < 24; i++) vals.push_back($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < 80; i++) begin
         step(1'b0, idx < 24, (idx < 24) ? vals[idx] : 0, 1'b0, a);
         if (a) idx++;
         if (InReady === 1'b0) saw_full = 1'b1;
         n_cmp++;
         if (obsv() !== expv()) begin
            n_fail++; $display("FAIL full_vec cyc=%0d dut=%h model=%h", i, obsv(), expv());
         end
      end
      n_cmp++;
      if (!saw_full || idx != 24) begin
         n_fail++; $display("FAIL full_backpressure saw_full=%b accepted=%0d required 1/24", saw_full, idx);
      end
      n_cmp++;
      if (en_log != vals) begin
         n_fail++; $display("FAIL full_order got=%p required=%p", en_log, vals);
      end
      n_cmp++;
      if (sums_obs.size() != 6) begin
         n_fail++; $display("FAIL full_frames got=%0d required=6", sums_obs.size());
      end
   endtask

`ifdef ACCUM_FEEDER_PAUSE_EN
   task automatic test_pause();
      logic a;
      int idx = 0;
      en_log.delete();
      for (int i = 0; i < 28; i++) begin
         step(1'b0, idx < 5, idx + 1, i < 8, a);
         if (a) idx++;
         n_cmp++;
         if (obsv() !== expv()) begin
            n_fail++; $display("FAIL pause_vec cyc=%0d dut=%h model=%h", i, obsv(), expv());
         end
         if (i == 7) begin
            n_cmp++;
            if (Level !== LW'(4) || InReady !== 1'b0 || idx != 4 || en_log.size() != 0) begin
               n_fail++; $display("FAIL pause_full Level=%0d InReady=%b accepted=%0d beats=%0d required 4/0/4/0", Level, InReady, idx, en_log.size());
            end
         end
      end
      n_cmp++;
      if (en_log != '{1, 2, 3, 4, 5}) begin
         n_fail++; $display("FAIL pause_order got=%p required 1..5", en_log);
      end
   endtask
`endif

   task automatic test_reset_mid();
      logic a;
      logic found = 1'b0;
      int fresh[4] = '{3, 5, 9, 11};
      for (int i = 0; i < 40 && !found; i++) begin
         if (m_tail == 0 && m_fed == 2 && m_q.size() >= 2) begin
            found = 1'b1;
         end else begin
            step(1'b0, 1'b1, $urandom_range(0, (1 << N) - 1), 1'b0, a);
            n_cmp++;
            if (obsv() !== expv()) begin
               n_fail++; $display("FAIL mid_vec cyc=%0d dut=%h model=%h", i, obsv(), expv());
            end
         end
      end
      n_cmp++;
      if (!found) begin
         n_fail++; $display("FAIL mid_reach found=0 required=1");
      end
      step(1'b1, 1'b1, 21, 1'b0, a);
      sums_obs.delete(); en_log.delete();
      n_cmp++;
      if ({Level, En, Clr} !== {LW'(0), 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL mid_reset Level=%0d En=%b Clr=%b required 0/0/1", Level, En, Clr);
      end
      for (int i = 0; i < 14; i++) begin
         step(1'b0, i < 4, (i < 4) ? fresh[i] : 0, 1'b0, a);
         n_cmp++;
         if (obsv() !== expv()) begin
            n_fail++; $display("FAIL mid_after_vec cyc=%0d dut=%h model=%h", i, obsv(), expv());
         end
      end
      n_cmp++;
      if (sums_obs.size() != 1 || sums_obs[0] != 28 || en_log.size() != 4) begin
         n_fail++; $display("FAIL mid_fresh_frame pulses=%0d beats=%0d sums=%p required 1/4/28", sums_obs.size(), en_log.size(), sums_obs);
      end
   endtask

   task automatic test_wrap();
      logic a;
      int idx = 0;
      int guard = 0;
      int exp_sums[5] = '{6, 22, 38, 54, 70};
      en_log.delete(); sums_obs.delete();
      while ((idx < 20 || guard < 400) && guard < 400) begin
         logic v;
         v = (idx < 20) && ($urandom_range(0, 99) < 60);
         step(1'b0, v, idx, 1'b0, a);
         if (a) idx++;
         guard++;
         n_cmp++;
         if (obsv() !== expv()) begin
            n_fail++; $display("FAIL wrap_vec cyc=%0d dut=%h model=%h", guard, obsv(), expv());
         end
         if (idx == 20 && guard < 380) guard = 380;
      end
      n_cmp++;
      if (idx != 20 || en_log.size() != 20) begin
         n_fail++; $display("FAIL wrap_count accepted=%0d beats=%0d required 20/20", idx, en_log.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (en_log[i] != i) begin
               n_fail++; $display("FAIL wrap_order idx=%0d got=%0d required=%0d", i, en_log[i], i);
            end
         end
      end
      n_cmp++;
      if (sums_obs.size() != 5) begin
         n_fail++; $display("FAIL wrap_frames got=%0d required=5", sums_obs.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (sums_obs[i] != exp_sums[i]) begin
               n_fail++; $display("FAIL wrap_sum frame=%0d got=%0d required=%0d", i, sums_obs[i], exp_sums[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_sparse();
      test_full();
`ifdef ACCUM_FEEDER_PAUSE_EN
      test_pause();
`endif
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
